i2c_master_nbyte: RTL and testbench

//  Parametrised I2C write master. Sends START, then num_bytes bytes (MSB first),

---
 rtl/i2c_master_nbyte_pkg.sv | 19 +
 rtl/i2c_master_nbyte_if.sv | 26 ++
 rtl/i2c_master_nbyte_quarter_tick.sv | 35 +++
 rtl/i2c_master_nbyte.sv | 142 ++++++++++++++
 tb/tb_i2c_master_nbyte.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_master_nbyte_pkg.sv
// Shared types and constants for the N-byte I2C write master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_master_nbyte_if.sv
// Request/status and SCL bundle between a host and the I2C write master.
interface i2c_master_nbyte_if #(
    parameter int MAX_BYTES = 4
);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    logic                   start;
    logic [CNT_W-1:0]       num_bytes;
    logic [8*MAX_BYTES-1:0] tx_data;
    logic                   i2c_sclk;
    logic                   busy;
    logic                   done;
    logic                   ack;
    logic [MAX_BYTES-1:0]   ack_mask;

    modport master (
        input  start, num_bytes, tx_data,
        output i2c_sclk, busy, done, ack, ack_mask
    );

    modport slave (
        output start, num_bytes, tx_data,
        input  i2c_sclk, busy, done, ack, ack_mask
    );

endinterface

// File: rtl/i2c_master_nbyte_quarter_tick.sv
// SCL quarter-period timebase: one tick every CLK_DIV clocks plus a 2-bit quarter index.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;

    assign tick = !clear && (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            quarter <= Q0;
        end else if (clear) begin
            div_cnt <= '0;
            quarter <= Q0;
        end else if (tick) begin
            div_cnt <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_nbyte.sv
// I2C write master: START, up to MAX_BYTES bytes each with an ACK slot, then STOP.
// Build option: define I2C_NACK_ABORT_EN to go to STOP right after the first NACK.
module i2c_master_nbyte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 4
) (
    input  logic               clk,
    input  logic               reset,
    i2c_master_nbyte_if.master bus,
    inout  wire                i2c_sdat
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    localparam int SW    = 8 * MAX_BYTES;
    localparam logic [MAX_BYTES-1:0] FIRST_BYTE = MAX_BYTES'(1) << (MAX_BYTES - 1);

    state_t               state, state_d;
    logic                 tick, div_clear;
    logic [1:0]           quarter, qn;
    logic [SW-1:0]        shreg;
    logic [2:0]           bit_cnt;
    logic [MAX_BYTES-1:0] cur_mask, sent_mask, ack_mask;
    logic                 scl_q, scl_d, sda_low_q, sda_low_d;
    logic                 done_q, ack_q, sda_in;
    logic                 accept, slot_end, sample_ack, last_byte, abort;

    // Byte masks are MSB-first: byte 0 lives in bit MAX_BYTES-1, like tx_data.
    function automatic logic [MAX_BYTES-1:0] sent_bits(input logic [CNT_W-1:0] n);
        logic [MAX_BYTES-1:0] ones;
        ones = '1;
        if (n >= CNT_W'(MAX_BYTES)) return ones;
        return ~(ones >> n);
    endfunction

    assign div_clear  = (state == IDLE);
    assign accept     = (state == IDLE) && bus.start;
    assign slot_end   = tick && (quarter == Q3);
    assign sample_ack = tick && (quarter == Q2) && (state == ACK);
    assign last_byte  = ((cur_mask >> 1) & sent_mask) == '0;
    assign sda_in     = i2c_sdat;

`ifdef I2C_NACK_ABORT_EN
    assign abort = (ack_mask & cur_mask) == '0;
`else
    assign abort = 1'b0;
`endif

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_quarter_tick (
        .clk     (clk),
        .reset   (reset),
        .clear   (div_clear),
        .tick    (tick),
        .quarter (quarter)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state;
        scl_d     = scl_q;
        sda_low_d = sda_low_q;
        qn        = quarter + 2'd1;
        case (state)
            IDLE:    if (bus.start) state_d = START;
            START:   if (slot_end) state_d = (sent_mask == '0) ? STOP : DATA;
            DATA:    if (slot_end && bit_cnt == 3'd0) state_d = ACK;
            ACK:     if (slot_end) state_d = (last_byte || abort) ? STOP : DATA;
            STOP:    if (slot_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Pin levels are registered for the quarter being entered on this tick.
        if (tick) begin
            scl_d = (state_d == IDLE) || (state_d == START) || (qn == Q2) || (qn == Q3);
            case (state_d)
                START: sda_low_d = (qn == Q2) || (qn == Q3);
                DATA:  if (qn == Q1) sda_low_d = (shreg[SW-1] != SDA_RELEASE);
                ACK:   if (qn == Q1) sda_low_d = 1'b0;
                STOP: begin
                    if (qn == Q1)      sda_low_d = 1'b1;
                    else if (qn == Q3) sda_low_d = 1'b0;
                end
                default: sda_low_d = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= 3'd7;
            cur_mask  <= '0;
            sent_mask <= '0;
            ack_mask  <= '0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
            done_q    <= 1'b0;
            if (accept) begin
                shreg     <= bus.tx_data;
                sent_mask <= sent_bits(bus.num_bytes);
                cur_mask  <= FIRST_BYTE;
                ack_mask  <= '0;
                ack_q     <= 1'b0;
                bit_cnt   <= 3'd7;
            end
            if (slot_end) begin
                case (state)
                    DATA: begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                    ACK:  cur_mask <= cur_mask >> 1;
                    STOP: begin
                        done_q <= 1'b1;
                        ack_q  <= &(ack_mask | ~sent_mask);
                    end
                    default: ;
                endcase
            end
            if (sample_ack) ack_mask <= ack_mask | (cur_mask & {MAX_BYTES{~sda_in}});
        end
    end

    assign i2c_sdat     = sda_low_q ? 1'b0 : 1'bz;
    assign bus.i2c_sclk = scl_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.ack      = ack_q;
    assign bus.ack_mask = ack_mask;

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Directed bench for i2c_master_nbyte with a pulled-up SDA line and a byte-capturing slave model.
module tb_i2c_master_nbyte;

    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 4;
    localparam int SLOT      = 4 * CLK_DIV;
    localparam int BOUND     = 2000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_master_nbyte_if #(.MAX_BYTES(MAX_BYTES)) bus ();

    wire  sda;
    logic slave_drive = 1'b0;
    pullup (sda);
    assign sda = slave_drive ? 1'b0 : 1'bz;

    i2c_master_nbyte #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .i2c_sdat (sda)
    );

    int compared   = 0;
    int mismatched = 0;

    // Slave model: detects START, shifts SDA on SCL rise, ACKs every byte except nack_byte.
    int         bitc = 0, bytec = 0, rx_count = 0, nack_byte = -1;
    logic [7:0] sh = 8'h00;
    logic [7:0] rx [8];
    logic       prev_scl = 1'b1, prev_sda = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            bitc = 0; bytec = 0; slave_drive = 1'b0;
            prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            if (prev_scl && bus.i2c_sclk && prev_sda && sda === 1'b0) begin
                bitc = 0; bytec = 0; rx_count = 0;
            end else if (!prev_scl && bus.i2c_sclk) begin
                if (bitc < 8) sh = {sh[6:0], sda === 1'b1};
                bitc++;
                if (bitc == 8 && rx_count < 8) begin
                    rx[rx_count] = sh;
                    rx_count++;
                end
            end else if (prev_scl && !bus.i2c_sclk) begin
                if (bitc == 8) slave_drive = (bytec != nack_byte);
                else if (bitc == 9) begin
                    slave_drive = 1'b0; bitc = 0; bytec++;
                end
            end
            prev_scl = bus.i2c_sclk;
            prev_sda = (sda === 1'b1);
        end
    end

    // Issues one request and returns clocks from the accepting edge to done.
    task automatic run_txn(input logic [2:0] n, input logic [31:0] data, input int nack,
                           input int restart_at, output int latency);
        nack_byte = nack;
        @(negedge clk);
        bus.start = 1'b1; bus.num_bytes = n; bus.tx_data = data;
        @(posedge clk); #1;
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_after_accept: got %b expected 1", bus.busy);
        end
        latency = 0;
        while (latency < BOUND) begin
            @(negedge clk);
            bus.start     = (restart_at != 0) && (latency == restart_at);
            bus.num_bytes = 3'd1;
            bus.tx_data   = 32'hFF00FF00;
            @(posedge clk);
            latency++;
            #1;
            if (bus.done === 1'b1) break;
        end
        compared++;
        if (latency >= BOUND || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL done_seen: latency %0d busy %b, required done within %0d with busy 0",
                     latency, bus.busy, BOUND);
        end
    endtask

    task automatic test_transfer(input string name, input logic [2:0] n, input logic [31:0] data,
                                 input int nack, input int restart_at, input int exp_lat,
                                 input int exp_cnt, input logic [3:0] exp_mask, input logic exp_ack);
        int lat;
        run_txn(n, data, nack, restart_at, lat);
        compared++;
        if (lat !== exp_lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        compared++;
        if (bus.ack !== exp_ack) begin
            mismatched++;
            $display("FAIL %s ack: got %b expected %b", name, bus.ack, exp_ack);
        end
        compared++;
        if (bus.ack_mask !== exp_mask) begin
            mismatched++;
            $display("FAIL %s ack_mask: got %b expected %b", name, bus.ack_mask, exp_mask);
        end
        compared++;
        if (rx_count !== exp_cnt) begin
            mismatched++;
            $display("FAIL %s byte_count: got %0d expected %0d", name, rx_count, exp_cnt);
        end
        for (int i = 0; i < exp_cnt && i < rx_count; i++) begin
            compared++;
            if (rx[i] !== data[31-8*i -: 8]) begin
                mismatched++;
                $display("FAIL %s byte%0d: got %h expected %h", name, i, rx[i], data[31-8*i -: 8]);
            end
        end
    endtask

    task automatic test_reset();
        logic idle_moved;
        bus.start = 1'b0; bus.num_bytes = '0; bus.tx_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({bus.i2c_sclk, sda === 1'b1, bus.busy, bus.done, bus.ack, bus.ack_mask} !== 9'b110000000) begin
            mismatched++;
            $display("FAIL reset_state: scl %b sda %b busy %b done %b ack %b mask %b, required 1 1 0 0 0 0000",
                     bus.i2c_sclk, sda, bus.busy, bus.done, bus.ack, bus.ack_mask);
        end
        @(negedge clk) reset = 1'b0;
        idle_moved = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.i2c_sclk !== 1'b1 || sda !== 1'b1 || bus.busy !== 1'b0) idle_moved = 1'b1;
        end
        compared++;
        if (idle_moved !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_quiet: got activity %b expected 0", idle_moved);
        end
    endtask

    task automatic test_basic();
        test_transfer("basic", 3'd3, 32'h341EA5C3, -1, 0, 29*SLOT, 3, 4'b1110, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if ({bus.ack, bus.ack_mask, bus.done} !== 6'b111100) begin
            mismatched++;
            $display("FAIL ack_hold: got ack %b mask %b done %b expected 1 1110 0",
                     bus.ack, bus.ack_mask, bus.done);
        end
    endtask

    task automatic test_nack();
`ifdef I2C_NACK_ABORT_EN
        test_transfer("nack", 3'd3, 32'h341EA5C3, 1, 0, 20*SLOT, 2, 4'b1000, 1'b0);
`else
        test_transfer("nack", 3'd3, 32'h341EA5C3, 1, 0, 29*SLOT, 3, 4'b1010, 1'b0);
`endif
    endtask

    task automatic test_zero_bytes();
        test_transfer("zero", 3'd0, 32'h5A5A5A5A, -1, 0, 2*SLOT, 0, 4'b0000, 1'b1);
    endtask

    task automatic test_clamp();
        test_transfer("clamp", 3'd7, 32'hDEADBEEF, -1, 0, 38*SLOT, 4, 4'b1111, 1'b1);
    endtask

    task automatic test_restart_ignored();
        test_transfer("restart", 3'd3, 32'h341EA5C3, -1, 100, 29*SLOT, 3, 4'b1110, 1'b1);
    endtask

    task automatic test_back_to_back();
        test_transfer("b2b_first", 3'd0, 32'h00000000, -1, 0, 2*SLOT, 0, 4'b0000, 1'b1);
        test_transfer("b2b_second", 3'd2, 32'hC0FFEE00, -1, 0, 20*SLOT, 2, 4'b1100, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.num_bytes = 3'd3; bus.tx_data = 32'h3416A5C3;
        nack_byte = -1;
        @(posedge clk);
        @(negedge clk) bus.start = 1'b0;
        repeat (14*SLOT + 6 - 1) @(posedge clk);
        #1;
        compared++;
        if ({bus.i2c_sclk, sda === 1'b1, bus.busy} !== 3'b001) begin
            mismatched++;
            $display("FAIL mid_byte1_bit3: scl %b sda %b busy %b, required 0 0 1",
                     bus.i2c_sclk, sda, bus.busy);
        end
        @(negedge clk) reset = 1'b1;
        #1;
        compared++;
        if ({bus.i2c_sclk, sda === 1'b1, bus.busy, bus.ack_mask} !== 7'b1100000) begin
            mismatched++;
            $display("FAIL async_reset: scl %b sda %b busy %b mask %b, required 1 1 0 0000",
                     bus.i2c_sclk, sda, bus.busy, bus.ack_mask);
        end
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        test_transfer("after_reset", 3'd3, 32'h341EA5C3, -1, 0, 29*SLOT, 3, 4'b1110, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nack();
        test_zero_bytes();
        test_clamp();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
